ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of key-event entries buffered; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock (25 MHz domain); all logic is on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port PS2_code, input, 8 bits: the last byte received by the PS/2 controller.
REQ-005 The block SHALL have port PS2_code_ready, input, 1 bit: level from the PS/2 controller; a 0->1 transition marks a new PS2_code byte.
REQ-006 The block SHALL have port Key_valid, output, 1 bit: the FIFO head holds an event.
REQ-007 The block SHALL have port Key_ready, input, 1 bit: the consumer accepts the head event when Key_valid=1 and Key_ready=1.
REQ-008 The block SHALL have port Key_code, output, 8 bits: the scan code of the head event.
REQ-009 The block SHALL have port Key_break, output, 1 bit: the head event is a release (1) or a press (0).
REQ-010 The block SHALL have port Key_extended, output, 1 bit: the head event was prefixed by E0.
REQ-011 The block SHALL have port Fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: the number of occupied entries.
REQ-012 The block SHALL have port Overflow, output, 1 bit: sticky; set when an event is dropped.

Function
REQ-013 A byte SHALL be captured at the clock edge where PS2_code_ready=1 and ready_buf=0; ready_buf is the registered copy of PS2_code_ready.
REQ-014 The parser FSM SHALL have the states IDLE, EXT, BRK and EXT_BRK.
REQ-015 When a byte is captured in IDLE: E0 -> EXT; F0 -> BRK; 00, FF or E1 -> discard and stay in IDLE; any other byte -> press event {ext=0}, stay in IDLE.
REQ-016 When a byte is captured in EXT: F0 -> EXT_BRK; E0 -> stay in EXT; 00, FF or E1 -> discard and go to IDLE; any other byte -> press event {ext=1}, go to IDLE.
REQ-017 When a byte is captured in BRK: any byte except 00, FF, E0 or F0 -> release event {ext=0}, go to IDLE; 00, FF, E0 or F0 -> discard and go to IDLE.
REQ-018 When a byte is captured in EXT_BRK: the byte SHALL be handled as in BRK, but the event has ext=1.
REQ-019 The FSM SHALL change state only on captured bytes.
REQ-020 An event SHALL be written to the FIFO at the capture edge, so that Key_valid rises 1 cycle after the capture edge when the FIFO was empty.
REQ-021 The FIFO SHALL be first-word-fall-through: Key_code, Key_break and Key_extended are valid whenever Key_valid=1 and stable until popped.
REQ-022 On a pop, the next entry (or Key_valid=0) SHALL appear the following cycle.
REQ-023 When a push and a pop occur in the same cycle, both SHALL be performed and Fifo_count SHALL be unchanged; this includes the FIFO-full case.
REQ-024 A push with the FIFO full and no pop SHALL drop the new event, leave the FIFO contents unchanged and set Overflow=1.
REQ-025 A pop with the FIFO empty SHALL be ignored.
REQ-026 The read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-028 On Reset=1 at a clock edge: FSM=IDLE; FIFO empty; Key_valid=0; Key_code=00; Key_break=0; Key_extended=0; Fifo_count=0; Overflow=0; typematic register cleared.
REQ-029 ready_buf SHALL reset to 1, so that a PS2_code_ready held high through reset is not captured as a new byte.
REQ-030 A reset arriving between a prefix byte and its code byte SHALL discard the partial sequence.
REQ-031 Overflow SHALL clear only on reset.

Configuration
REQ-032 With PS2_KEY_TYPEMATIC_FILTER_EN defined, the block SHALL hold register last_make {valid, ext, code}.
REQ-033 With PS2_KEY_TYPEMATIC_FILTER_EN defined: a press event whose {ext, code} matches last_make while valid=1 SHALL be suppressed, with no push and no Overflow change.
REQ-034 With PS2_KEY_TYPEMATIC_FILTER_EN defined: any other press event SHALL load last_make, and a release matching last_make SHALL clear valid; a non-matching release leaves it unchanged.
REQ-035 Without PS2_KEY_TYPEMATIC_FILTER_EN, every press event SHALL be pushed and the last_make register SHALL not exist.

Structure
REQ-036 Package ps2_key_pkg SHALL hold: the FSM state enum; the constants PS2_EXT_PREFIX=8'hE0, PS2_BREAK_PREFIX=8'hF0 and PS2_PAUSE_PREFIX=8'hE1; the typedef key_event_t {break, extended, code[7:0]}; and the FIFO_DEPTH default.
REQ-037 The FIFO SHALL be the sub-module ps2_event_fifo, parameterised by depth and carrying key_event_t entries; the parser and the typematic filter stay in ps2_key_decoder.

Verification
REQ-038 The bench SHALL drive rising edges of PS2_code_ready with bytes 1C, then F0 1C, with Key_ready=1 -> events {1C, break=0, ext=0} then {1C, break=1, ext=0}; Key_valid first rises 1 cycle after the 1C capture.
REQ-039 The bench SHALL drive E0 75 E0 F0 75 -> events {75, break=0, ext=1} then {75, break=1, ext=1}; the FSM returns to IDLE.
REQ-040 The bench SHALL hold Key_ready=0, send 5 make codes 15 1D 1C 1B 4B with FIFO_DEPTH=4 and then pop all -> events 15 1D 1C 1B; Overflow=1; Fifo_count peaks at 4.
REQ-041 The bench SHALL fill the FIFO, then capture a byte in the same cycle as a pop -> no drop; Overflow stays 0; Fifo_count stays 4.
REQ-042 The bench SHALL hold PS2_code_ready=1 with PS2_code=1C while asserting and releasing Reset -> no event; the next 0->1 edge with 1B -> {1B, break=0, ext=0}.
REQ-043 With PS2_KEY_TYPEMATIC_FILTER_EN defined, the bench SHALL send 1C 1C 1C F0 1C 1C -> events: press 1C, release 1C, press 1C; without the macro -> 5 events.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 key decoder: parser states,
// scan-code prefixes, the buffered key-event record and byte classifiers.
package ps2_key_pkg;

  localparam int PS2_FIFO_DEPTH_DEFAULT = 4;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_PAUSE_PREFIX = 8'hE1;
  localparam logic [7:0] PS2_NULL_BYTE    = 8'h00;
  localparam logic [7:0] PS2_ERROR_BYTE   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic       extended;
    logic [7:0] code;
  } key_event_t;

  // Bytes that never form an event in the press path and abort any prefix.
  function automatic logic is_filler_byte(input logic [7:0] b);
    return (b == PS2_NULL_BYTE) || (b == PS2_ERROR_BYTE) || (b == PS2_PAUSE_PREFIX);
  endfunction

  // Bytes that cannot legally follow a break prefix.
  function automatic logic is_break_discard(input logic [7:0] b);
    return (b == PS2_NULL_BYTE) || (b == PS2_ERROR_BYTE) ||
           (b == PS2_EXT_PREFIX) || (b == PS2_BREAK_PREFIX);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key-event stream between the decoder (master) and its consumer (slave):
// valid/ready handshake carrying scan code, break and extended flags.
interface ps2_key_decoder_if;
  logic       Key_valid;
  logic       Key_ready;
  logic [7:0] Key_code;
  logic       Key_break;
  logic       Key_extended;

  modport master (
    output Key_valid,
    output Key_code,
    output Key_break,
    output Key_extended,
    input  Key_ready
  );

  modport slave (
    input  Key_valid,
    input  Key_code,
    input  Key_break,
    input  Key_extended,
    output Key_ready
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO of key events with simultaneous push/pop
// (even when full), drop-on-full and a sticky overflow flag.
module ps2_event_fifo
  import ps2_key_pkg::*;
#(
  parameter int DEPTH = PS2_FIFO_DEPTH_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  key_event_t                 push_data_i,
  input  logic                       pop_i,
  output key_event_t                 head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  key_event_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty_s, full_s, do_pop_s, do_push_s, drop_s;

  assign empty_s   = (cnt_q == {CW{1'b0}});
  assign full_s    = (cnt_q == CNT_FULL);
  assign do_pop_s  = pop_i & ~empty_s;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push_s = push_i & (~full_s | do_pop_s);
  assign drop_s    = push_i & full_s & ~do_pop_s;

  // Pointer, occupancy and overflow next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | drop_s;
    if (do_push_s) begin
      wr_d = (wr_q == PTR_LAST) ? {AW{1'b0}} : (wr_q + PTR_ONE);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = (rd_q == PTR_LAST) ? {AW{1'b0}} : (rd_q + PTR_ONE);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
      ovf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (do_push_s) begin
        mem_q[wr_q] <= push_data_i;
      end
    end
  end

  assign valid_o    = ~empty_s;
  assign head_o     = empty_s ? key_event_t'('0) : mem_q[rd_q];
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 parser feeding a key-event FIFO. Optional typematic
// repeat suppression is enabled with PS2_KEY_TYPEMATIC_FILTER_EN.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH = PS2_FIFO_DEPTH_DEFAULT
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [7:0]                   PS2_code,
  input  logic                         PS2_code_ready,
  ps2_key_decoder_if.master            key_if,
  output logic [$clog2(FIFO_DEPTH):0]  Fifo_count,
  output logic                         Overflow
);

  ps2_state_e state_q, state_d;
  logic       ready_buf_q;
  logic       capture_s;
  logic       ev_valid_s;
  key_event_t ev_s;
  logic       suppress_s;
  logic       push_s;
  logic       pop_s;
  logic       fifo_valid_s;
  key_event_t head_s;

  assign capture_s = PS2_code_ready & ~ready_buf_q;

  // Parser next-state and event decode on captured bytes.
  always_comb begin
    state_d     = state_q;
    ev_valid_s  = 1'b0;
    ev_s        = '0;
    ev_s.code   = PS2_code;
    if (capture_s) begin
      case (state_q)
        IDLE: begin
          if (PS2_code == PS2_EXT_PREFIX) begin
            state_d = EXT;
          end else if (PS2_code == PS2_BREAK_PREFIX) begin
            state_d = BRK;
          end else if (is_filler_byte(PS2_code)) begin
            state_d = IDLE;
          end else begin
            ev_valid_s = 1'b1;
          end
        end
        EXT: begin
          if (PS2_code == PS2_BREAK_PREFIX) begin
            state_d = EXT_BRK;
          end else if (PS2_code == PS2_EXT_PREFIX) begin
            state_d = EXT;
          end else if (is_filler_byte(PS2_code)) begin
            state_d = IDLE;
          end else begin
            ev_valid_s    = 1'b1;
            ev_s.extended = 1'b1;
            state_d       = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          state_d = IDLE;
          if (!is_break_discard(PS2_code)) begin
            ev_valid_s    = 1'b1;
            ev_s.brk      = 1'b1;
            ev_s.extended = (state_q == EXT_BRK);
          end else begin
            ev_valid_s = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Parser state and edge-detect register; ready_buf resets high so a level
  // held through reset is not mistaken for a fresh byte.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      ready_buf_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ready_buf_q <= PS2_code_ready;
    end
  end

`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
  logic       lm_valid_q, lm_valid_d;
  logic       lm_ext_q, lm_ext_d;
  logic [7:0] lm_code_q, lm_code_d;
  logic       lm_match_s;

  assign lm_match_s = lm_valid_q && (lm_ext_q == ev_s.extended) && (lm_code_q == ev_s.code);

  // Track the held key; auto-repeat makes of it are swallowed until release.
  always_comb begin
    lm_valid_d = lm_valid_q;
    lm_ext_d   = lm_ext_q;
    lm_code_d  = lm_code_q;
    suppress_s = 1'b0;
    if (ev_valid_s && !ev_s.brk) begin
      if (lm_match_s) begin
        suppress_s = 1'b1;
      end else begin
        lm_valid_d = 1'b1;
        lm_ext_d   = ev_s.extended;
        lm_code_d  = ev_s.code;
      end
    end else if (ev_valid_s && ev_s.brk && lm_match_s) begin
      lm_valid_d = 1'b0;
    end else begin
      lm_valid_d = lm_valid_q;
    end
  end

  // Last-make register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lm_valid_q <= 1'b0;
      lm_ext_q   <= 1'b0;
      lm_code_q  <= 8'h00;
    end else begin
      lm_valid_q <= lm_valid_d;
      lm_ext_q   <= lm_ext_d;
      lm_code_q  <= lm_code_d;
    end
  end
`else
  assign suppress_s = 1'b0;
`endif

  assign push_s = ev_valid_s & ~suppress_s;
  assign pop_s  = fifo_valid_s & key_if.Key_ready;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .push_i      (push_s),
    .push_data_i (ev_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .valid_o     (fifo_valid_s),
    .count_o     (Fifo_count),
    .overflow_o  (Overflow)
  );

  assign key_if.Key_valid    = fifo_valid_s;
  assign key_if.Key_code     = head_s.code;
  assign key_if.Key_break    = head_s.brk;
  assign key_if.Key_extended = head_s.extended;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (FIFO_DEPTH=4); event
// expectations adapt to PS2_KEY_TYPEMATIC_FILTER_EN.
module tb_ps2_key_decoder;
  import ps2_key_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] ps2_code;
  logic       ps2_rdy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] evq[$];

  ps2_key_decoder_if kif();

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .Clock          (clk),
    .Reset          (rst),
    .PS2_code       (ps2_code),
    .PS2_code_ready (ps2_rdy),
    .key_if         (kif.master),
    .Fifo_count     (fifo_count),
    .Overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each accepted event {break, extended, code}; pops happen at the next rising edge.
  always @(negedge clk) begin
    if (kif.Key_valid === 1'b1 && kif.Key_ready === 1'b1)
      evq.push_back({kif.Key_break, kif.Key_extended, kif.Key_code});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(1);
    ps2_code = b;
    ps2_rdy  = 1'b1;
    tick(1);
    ps2_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic check_events(input string tag, input logic [9:0] exp[$]);
    check({tag, "_n"}, evq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < evq.size()) check($sformatf("%s_ev%0d", tag, i), evq[i], exp[i]);
    end
    evq.delete();
  endtask

  initial begin
    logic [9:0] exp_ev[$];
    rst = 1'b1; ps2_code = 8'h00; ps2_rdy = 1'b0; kif.Key_ready = 1'b1;
    do_reset();
    check("rst_valid", kif.Key_valid, 1'b0);
    check("rst_code", kif.Key_code, 8'h00);
    check("rst_break", kif.Key_break, 1'b0);
    check("rst_ext", kif.Key_extended, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ovf", overflow, 1'b0);

    // Make 1C with latency check, then break F0 1C
    tick(1);
    ps2_code = 8'h1C; ps2_rdy = 1'b1;
    check("lat_before", kif.Key_valid, 1'b0);
    tick(1);
    check("lat_after", kif.Key_valid, 1'b1);
    check("lat_code", kif.Key_code, 8'h1C);
    ps2_rdy = 1'b0;
    send_byte(8'hF0); send_byte(8'h1C); tick(3);
    exp_ev = '{10'h01C, 10'h21C};
    check_events("make_break", exp_ev);

    // Extended make and break
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    tick(3);
    exp_ev = '{10'h175, 10'h375};
    check_events("ext", exp_ev);
    check("ext_state", dut.state_q, IDLE);

    // Filler bytes, repeated E0, and discarded F0 E0
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hE1);
    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h5A);
    send_byte(8'hF0); send_byte(8'hE0); tick(3);
    exp_ev = '{10'h15A};
    check_events("filler", exp_ev);
    check("filler_state", dut.state_q, IDLE);

    // Overflow: five makes into a depth-4 FIFO with no consumer
    kif.Key_ready = 1'b0;
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h1C); send_byte(8'h1B); send_byte(8'h4B);
    tick(1);
    check("ovf_count", fifo_count, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", kif.Key_code, 8'h15);
    kif.Key_ready = 1'b1;
    tick(8);
    exp_ev = '{10'h015, 10'h01D, 10'h01C, 10'h01B};
    check_events("ovf", exp_ev);
    check("ovf_drained", kif.Key_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    do_reset();
    check("ovf_cleared", overflow, 1'b0);

    // Push and pop in the same cycle while full
    kif.Key_ready = 1'b0;
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
    check("full_count", fifo_count, 3'd4);
    tick(1);
    ps2_code = 8'h25; ps2_rdy = 1'b1; kif.Key_ready = 1'b1;
    tick(1);
    kif.Key_ready = 1'b0; ps2_rdy = 1'b0;
    check("pp_count", fifo_count, 3'd4);
    check("pp_ovf", overflow, 1'b0);
    check("pp_head", kif.Key_code, 8'h22);
    kif.Key_ready = 1'b1;
    tick(8);
    exp_ev = '{10'h021, 10'h022, 10'h023, 10'h024, 10'h025};
    check_events("pp", exp_ev);

    // Ready held high through reset
    ps2_code = 8'h1C; ps2_rdy = 1'b1;
    do_reset();
    tick(3);
    check("hold_count", fifo_count, 3'd0);
    check("hold_valid", kif.Key_valid, 1'b0);
    ps2_rdy = 1'b0;
    send_byte(8'h1B); tick(3);
    exp_ev = '{10'h01B};
    check_events("hold", exp_ev);

    // Reset between prefix and code discards the prefix
    send_byte(8'hE0);
    do_reset();
    send_byte(8'h1A); tick(3);
    exp_ev = '{10'h01A};
    check_events("partial", exp_ev);

    // Typematic repeat
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C); tick(3);
`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
    exp_ev = '{10'h01C, 10'h21C, 10'h01C};
`else
    exp_ev = '{10'h01C, 10'h01C, 10'h01C, 10'h21C, 10'h01C};
`endif
    check_events("typematic", exp_ev);
    check("final_ovf", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
